// File: rtl/mbr_store.sv
// Store path from accumulator to memory: registered four-state write handshake with timeout.
// Optional build macro MBR_STORE_QUEUE_EN adds a one-entry pending slot for store strobes that arrive while busy.
`timescale 1ns/1ps
module mbr_store #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C12,
    input  logic [DATA_W-1:0] ACC_in,
    input  logic [ADDR_W-1:0] MAR_in,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    // The last REQ cycle is the one where the counter holds TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

`ifdef MBR_STORE_QUEUE_EN
    logic              slot_full_reg, slot_full_next;
    logic [ADDR_W-1:0] slot_addr_reg, slot_addr_next;
    logic [DATA_W-1:0] slot_data_reg, slot_data_next;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
`ifdef MBR_STORE_QUEUE_EN
        slot_full_next = slot_full_reg;
        slot_addr_next = slot_addr_reg;
        slot_data_next = slot_data_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (C12) begin
                    state_next = ST_REQ;
                    we_next    = 1'b1;
                    cnt_next   = 8'd0;
                    addr_next  = MAR_in;
                    wdata_next = ACC_in;
                    err_next   = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_next = ST_DONE;
                    we_next    = 1'b0;
                    done_next  = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FAIL;
                    we_next    = 1'b0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
`ifdef MBR_STORE_QUEUE_EN
                if (C12) begin
                    if (!slot_full_reg) begin
                        slot_full_next = 1'b1;
                        slot_addr_next = MAR_in;
                        slot_data_next = ACC_in;
                    end else begin
                        err_next = 1'b1;
                    end
                end
`else
                if (C12) begin
                    err_next = 1'b1;
                end
`endif
            end
            default: begin
                // DONE and FAIL both last one cycle before returning to IDLE or relaunching.
                state_next = ST_IDLE;
`ifdef MBR_STORE_QUEUE_EN
                if (slot_full_reg) begin
                    state_next     = ST_REQ;
                    we_next        = 1'b1;
                    cnt_next       = 8'd0;
                    addr_next      = slot_addr_reg;
                    wdata_next     = slot_data_reg;
                    slot_full_next = 1'b0;
                    if (C12) begin
                        slot_full_next = 1'b1;
                        slot_addr_next = MAR_in;
                        slot_data_next = ACC_in;
                    end
                end else if (C12) begin
                    state_next = ST_REQ;
                    we_next    = 1'b1;
                    cnt_next   = 8'd0;
                    addr_next  = MAR_in;
                    wdata_next = ACC_in;
                end
`else
                if (C12) begin
                    err_next = 1'b1;
                end
`endif
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

`ifdef MBR_STORE_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_reg <= 1'b0;
            slot_addr_reg <= '0;
            slot_data_reg <= '0;
        end else begin
            slot_full_reg <= slot_full_next;
            slot_addr_reg <= slot_addr_next;
            slot_data_reg <= slot_data_next;
        end
    end
`endif

    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mbr_store.sv
// Directed bench for mbr_store; one task per scenario, expected values written by hand.
`timescale 1ns/1ps
module tb_mbr_store;

    logic        clk;
    logic        rst;
    logic        C12;
    logic [15:0] ACC_in;
    logic [7:0]  MAR_in;
    logic        mem_ack;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    mbr_store #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .C12(C12), .ACC_in(ACC_in), .MAR_in(MAR_in),
        .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; C12 = 1'b0; ACC_in = '0; MAR_in = '0; mem_ack = 1'b0;
        repeat (3) tick();
        checks++;
        if ({mem_we, busy, done, err, mem_addr, mem_wdata} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b busy=%b done=%b err=%b addr=%h data=%h, want all 0",
                     mem_we, busy, done, err, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_basic();
        int we_cycles = 0;
        int done_cnt = 0;
        C12 = 1'b1; ACC_in = 16'hA5C3; MAR_in = 8'h2F;
        tick();
        C12 = 1'b0; ACC_in = 16'h0000; MAR_in = 8'h00;
        checks++;
        if (mem_we !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req: got we=%b busy=%b, want 1 1", mem_we, busy);
        end
        checks++;
        if (mem_addr !== 8'h2F || mem_wdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL basic_data: got addr=%h data=%h, want 2F A5C3", mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (mem_we) we_cycles++;
            tick();
            mem_ack = 1'b0;
            if (done) done_cnt++;
            if (i == 0) begin
                checks++;
                if (done !== 1'b1 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done_edge: got done=%b we=%b, want 1 0", done, mem_we);
                end
            end
        end
        checks++;
        if (we_cycles != 1 || done_cnt != 1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_summary: got we_cycles=%0d dones=%0d err=%b busy=%b, want 1 1 0 0",
                     we_cycles, done_cnt, err, busy);
        end
        $display("basic write addr=%h data=%h we_cycles=%0d dones=%0d", mem_addr, mem_wdata, we_cycles, done_cnt);
    endtask

    task automatic test_timeout();
        int we_cycles = 0;
        int done_cnt = 0;
        C12 = 1'b1; ACC_in = 16'h1234; MAR_in = 8'h40;
        for (int i = 0; i < 30; i++) begin
            tick();
            C12 = 1'b0;
            if (mem_we) we_cycles++;
            if (done) done_cnt++;
        end
        checks++;
        if (we_cycles != 15) begin
            errors++;
            $display("FAIL timeout_we_width: got %0d cycles, want 15", we_cycles);
        end
        checks++;
        if (done_cnt != 0 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got dones=%0d err=%b busy=%b, want 0 1 0", done_cnt, err, busy);
        end
        C12 = 1'b1; ACC_in = 16'h5678; MAR_in = 8'h41;
        tick();
        C12 = 1'b0;
        checks++;
        if (err !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h41) begin
            errors++;
            $display("FAIL timeout_err_clear: got err=%b we=%b addr=%h, want 0 1 41", err, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        $display("timeout we_cycles=%0d dones=%0d then err cleared by new store", we_cycles, done_cnt);
    endtask

    task automatic test_late_ack();
        C12 = 1'b1; ACC_in = 16'hBEEF; MAR_in = 8'h7E;
        tick();
        C12 = 1'b0;
        repeat (14) tick();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL late_ack_still_req: got we=%b in 15th cycle, want 1", mem_we);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_done: got done=%b err=%b we=%b, want 1 0 0", done, err, mem_we);
        end
        tick();
        $display("late ack in final REQ cycle done=%b err=%b", done, err);
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        C12 = 1'b1; ACC_in = 16'hCAFE; MAR_in = 8'h99;
        tick();
        C12 = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, busy, done, err, mem_addr, mem_wdata} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got we=%b busy=%b done=%b err=%b addr=%h data=%h, want all 0",
                     mem_we, busy, done, err, mem_addr, mem_wdata);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ack = (i == 1);
            tick();
            if (done || mem_we) done_cnt++;
        end
        mem_ack = 1'b0;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got activity=%0d busy=%b, want 0 0", done_cnt, busy);
        end
        $display("reset mid REQ cleared outputs, post-release activity=%0d", done_cnt);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  log_addr [4];
        logic [15:0] log_data [4];
        int n_wr = 0;
        int done_cnt = 0;
        int exp_wr;
        logic exp_err;
`ifdef MBR_STORE_QUEUE_EN
        exp_wr = 2; exp_err = 1'b0;
`else
        exp_wr = 1; exp_err = 1'b1;
`endif
        C12 = 1'b1; ACC_in = 16'h1111; MAR_in = 8'h01;
        tick();
        C12 = 1'b0;
        tick();
        C12 = 1'b1; ACC_in = 16'h2222; MAR_in = 8'h02;
        tick();
        C12 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mem_ack = mem_we;
            if (mem_we && n_wr < 4) begin
                log_addr[n_wr] = mem_addr;
                log_data[n_wr] = mem_wdata;
                n_wr++;
            end
            tick();
            if (done) done_cnt++;
        end
        mem_ack = 1'b0;
        checks++;
        if (n_wr != exp_wr || done_cnt != exp_wr || err !== exp_err) begin
            errors++;
            $display("FAIL b2b_counts: got writes=%0d dones=%0d err=%b, want %0d %0d %b",
                     n_wr, done_cnt, err, exp_wr, exp_wr, exp_err);
        end
        checks++;
        if (n_wr < 1 || log_addr[0] !== 8'h01 || log_data[0] !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_first: got writes=%0d addr=%h data=%h, want 01 1111",
                     n_wr, log_addr[0], log_data[0]);
        end
`ifdef MBR_STORE_QUEUE_EN
        checks++;
        if (n_wr < 2 || log_addr[1] !== 8'h02 || log_data[1] !== 16'h2222) begin
            errors++;
            $display("FAIL b2b_second: got writes=%0d addr=%h data=%h, want 02 2222",
                     n_wr, log_addr[1], log_data[1]);
        end
`endif
        $display("back to back writes=%0d dones=%0d err=%b", n_wr, done_cnt, err);
    endtask

    task automatic test_ack_idle();
        logic exp_err;
`ifdef MBR_STORE_QUEUE_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0 || err !== exp_err) begin
            errors++;
            $display("FAIL ack_idle: got busy=%b done=%b we=%b err=%b, want 0 0 0 %b",
                     busy, done, mem_we, err, exp_err);
        end
        checks++;
        if (mem_addr !== 8'h02 && mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL ack_idle_addr_hold: got addr=%h, want last written address", mem_addr);
        end
        $display("ack in IDLE ignored busy=%b err=%b addr=%h", busy, err, mem_addr);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_late_ack();
        test_reset_mid();
        test_back_to_back();
        test_ack_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
